// File: rtl/bounded_updown_counter.sv
// Up/down counter with programmable step, runtime [min_val, max_val] bounds,
// wrap or saturate on bound crossing, clamped parallel load and sticky flags.
module bounded_updown_counter #(
    parameter int WIDTH  = 32,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              upDown,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  min_val,
    input  logic [WIDTH-1:0]  max_val,
    input  logic              sat_mode,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_value,
    input  logic              clear_flags,
    output logic [WIDTH-1:0]  count,
    output logic              at_max,
    output logic              at_min,
    output logic              cross_pulse,
    output logic              overflow_sticky,
    output logic              underflow_sticky,
    output logic              cfg_err
);

    localparam int EW = WIDTH + 1;

    typedef logic [EW-1:0] ext_t;

    typedef struct packed {
        logic [WIDTH-1:0] cnt;
        logic             up_cross;
        logic             dn_cross;
    } nxt_t;

    ext_t             cnt_x, min_x, max_x, step_x;
    ext_t             up_sum, dn_thr;
    logic [WIDTH-1:0] step_w;
    logic [WIDTH-1:0] load_clamped;
    logic             up_fits, dn_fits;
    logic             below, above;
    nxt_t             nxt;

    assign cfg_err = (min_val > max_val);
    assign at_max  = (count == max_val);
    assign at_min  = (count == min_val);

    // One extra bit keeps count+step and min+step free of wrap-around.
    assign cnt_x  = EW'(count);
    assign min_x  = EW'(min_val);
    assign max_x  = EW'(max_val);
    assign step_x = EW'(step);
    assign step_w = WIDTH'(step);

    assign up_sum  = cnt_x + step_x;
    assign dn_thr  = min_x + step_x;
    assign up_fits = (up_sum <= max_x);
    assign dn_fits = (cnt_x >= dn_thr);

    assign below = (count < min_val);
    assign above = (count > max_val);

    always_comb begin
        load_clamped = load_value;
        if (load_value < min_val)
            load_clamped = min_val;
        else if (load_value > max_val)
            load_clamped = max_val;
    end

    // Priority: bad config > load > out-of-range clamp > count > hold.
    always_comb begin
        nxt.cnt      = count;
        nxt.up_cross = 1'b0;
        nxt.dn_cross = 1'b0;
        if (!cfg_err) begin
            if (load) begin
                nxt.cnt = load_clamped;
            end else if (enable) begin
                if (below) begin
                    nxt.cnt = min_val;
                end else if (above) begin
                    nxt.cnt = max_val;
                end else if (upDown) begin
                    if (up_fits) begin
                        nxt.cnt = up_sum[WIDTH-1:0];
                    end else begin
                        nxt.up_cross = 1'b1;
                        nxt.cnt      = sat_mode ? max_val : min_val;
                    end
                end else begin
                    if (dn_fits) begin
                        nxt.cnt = count - step_w;
                    end else begin
                        nxt.dn_cross = 1'b1;
                        nxt.cnt      = sat_mode ? min_val : max_val;
                    end
                end
            end
        end
    end

    // A set in the same cycle as clear_flags leaves the flag asserted.
    always_ff @(posedge clk) begin
        if (reset) begin
            count            <= cfg_err ? '0 : min_val;
            cross_pulse      <= 1'b0;
            overflow_sticky  <= 1'b0;
            underflow_sticky <= 1'b0;
        end else begin
            count            <= nxt.cnt;
            cross_pulse      <= nxt.up_cross | nxt.dn_cross;
            overflow_sticky  <= nxt.up_cross | (overflow_sticky & ~clear_flags);
            underflow_sticky <= nxt.dn_cross | (underflow_sticky & ~clear_flags);
        end
    end

endmodule

// File: doc/bounded_updown_counter.md
# bounded_updown_counter

Parametrised up/down counter: successor to the fixed 32-bit, step-of-one counter. Adds a programmable step, runtime lower/upper bounds, wrap or saturate mode on bound crossing, parallel load, bound-status outputs, a crossing pulse, and sticky overflow/underflow flags. It sits beside the existing counter in timer, PWM and address-generation datapaths that need a modulus or a clamp rather than free-running 2^N wrap.

## Interface
- WIDTH, 32, counter and bound width (≥2)
- STEP_W, 8, width of the step input (1 ≤ STEP_W ≤ WIDTH)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = count this cycle, 0 = hold
- upDown  in  1  1 = count up, 0 = count down
- step  in  STEP_W  unsigned increment/decrement per enabled cycle
- min_val  in  WIDTH  unsigned lower bound (inclusive)
- max_val  in  WIDTH  unsigned upper bound (inclusive)
- sat_mode  in  1  1 = saturate at bound, 0 = reload opposite bound on crossing
- load  in  1  parallel load request
- load_value  in  WIDTH  value for load
- clear_flags  in  1  clears sticky flags
- count  out  WIDTH  registered counter value
- at_max  out  1  combinational, count == max_val
- at_min  out  1  combinational, count == min_val
- cross_pulse  out  1  registered, one-cycle pulse on a bound crossing
- overflow_sticky  out  1  registered, set on an up-crossing
- underflow_sticky  out  1  registered, set on a down-crossing
- cfg_err  out  1  combinational, min_val > max_val

## Operation
- All arithmetic is unsigned. Compute sums in WIDTH+1 bits; compute down checks as count < min_val + step, also in WIDTH+1 bits. No intermediate wraps.
- Priority per edge: reset > cfg_err hold > load > out-of-range clamp > enable count > hold.
- reset: count ← min_val, or 0 if cfg_err. cross_pulse, overflow_sticky and underflow_sticky ← 0.
- cfg_err = 1: count holds and load is ignored. cross_pulse = 0. Sticky flags still honour clear_flags.
- load: count ← load_value clamped to [min_val, max_val]. No crossing event. Takes precedence over enable.
- Out-of-range: if enable = 1 and count < min_val or count > max_val (bounds changed at runtime), count ← nearest bound. No event.
- Up, enable = 1, upDown = 1:
  - If count + step ≤ max_val, count ← count + step.
  - Otherwise it is an up-crossing: count ← max_val if sat_mode, else min_val.
- Down, enable = 1, upDown = 0:
  - If count ≥ min_val + step, count ← count − step.
  - Otherwise it is a down-crossing: count ← min_val if sat_mode, else max_val.
- step = 0: count holds and no crossing occurs.
- Saturate mode sitting at a bound with step > 0 counts as a crossing every enabled cycle. cross_pulse stays high for as long as the condition persists.
- cross_pulse = 1 for exactly the cycle after each crossing edge, otherwise 0.
- overflow_sticky is set by an up-crossing; underflow_sticky is set by a down-crossing. Both are cleared by clear_flags. Set wins over clear in the same cycle.

## Timing
- Latency: one cycle from enable/load/reset sampling to the new count. cross_pulse and sticky flags update on the same edge as count.
- at_max, at_min and cfg_err are combinational from the current count and bounds, with zero latency.
- No handshake. Every input is sampled on every rising edge.
- Reset mid-count overrides a simultaneous load, enable or clear_flags.
- min_val == max_val is legal: count is pinned, and every enabled non-zero step is a crossing.

## Test plan (WIDTH=8, STEP_W=4)
- Reset, min=10, max=20, then enable, up, step=3 for 4 cycles -> count 10,13,16,19, then 10 on the 4th edge (wrap mode). cross_pulse high one cycle; overflow_sticky=1.
- Same setup with sat_mode=1 -> count 10,13,16,19,20,20. cross_pulse high on the 20→20 cycles; at_max=1.
- min=0, max=255, count=2, down, step=5, wrap mode -> count 255, underflow_sticky=1. Next enabled cycle -> 250.
- load=1 with enable=1, load_value=50, bounds [10,40] -> count 40, no cross_pulse. clear_flags and a crossing in the same cycle -> flag stays 1.
- Count=30, then max_val changed to 25 with enable=1 -> count 25 with no event. Then min=30, max=25 -> cfg_err=1, count holds, load ignored.
- Reset asserted together with load and enable mid-count -> count=min_val, all flags 0 on the next cycle.
